demux14_buffered: RTL and testbench

- 1-to-4 routing stage for the ALU datapath; the inverse of the 4:1 result multiplexer.
- Accepts one N-bit word per handshake with a 2-bit destination select and delivers it to one of four output channels.
- Each channel has a 2-entry FIFO, so downstream back-pressure on one channel does not stall traffic to the others.

---
 rtl/demux14_buffered.sv | 123 ++++++++++++
 tb/tb_demux14_buffered.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux14_buffered.sv
// demux14_buffered: 1-to-4 routing stage for the ALU datapath.
// Each input word is steered by in_sel into one of four 2-entry FIFOs.
// Back-pressure on one channel therefore does not stall traffic to the others.
// Optional feature macro: DEMUX41_COUNT_EN adds per-channel delivered-word
// counters (xfer_cnt0..3) and a synchronous clear input (cnt_clear).
module demux14_buffered #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [1:0]   in_sel,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [N-1:0] out_data0,
  output logic [N-1:0] out_data1,
  output logic [N-1:0] out_data2,
  output logic [N-1:0] out_data3
`ifdef DEMUX41_COUNT_EN
  ,
  input  logic         cnt_clear,
  output logic [15:0]  xfer_cnt0,
  output logic [15:0]  xfer_cnt1,
  output logic [15:0]  xfer_cnt2,
  output logic [15:0]  xfer_cnt3
`endif
);

  logic [1:0]   w_cnt  [4];
  logic [N-1:0] w_head [4];
  logic [3:0]   w_push;
  logic [3:0]   w_pop;

  // in_ready depends only on the occupancy of the selected channel,
  // so there is no combinational path from out_ready back to in_ready.
  assign in_ready = (w_cnt[in_sel] != 2'd2);

  // Decode the accepted word into a one-hot push and form per-channel pops.
  always_comb begin
    w_push = 4'b0000;
    if (in_valid && in_ready) begin
      w_push[in_sel] = 1'b1;
    end
    w_pop = out_valid & out_ready;
  end

  // A channel presents a word whenever its FIFO is non-empty.
  always_comb begin
    out_valid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      out_valid[k] = (w_cnt[k] != 2'd0);
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic [N-1:0] r_mem [2];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_cnt;

    // Per-channel FIFO: storage, 1-bit wrapping pointers, occupancy 0..2.
    // Storage is cleared on reset so the head reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_mem[0] <= '0;
        r_mem[1] <= '0;
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
        r_cnt    <= 2'd0;
      end else begin
        if (w_push[k]) begin
          r_mem[r_wr_ptr] <= in_data;
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_pop[k]) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        case ({w_push[k], w_pop[k]})
          2'b10:   r_cnt <= r_cnt + 2'd1;
          2'b01:   r_cnt <= r_cnt - 2'd1;
          default: r_cnt <= r_cnt;
        endcase
      end
    end

    assign w_cnt[k]  = r_cnt;
    assign w_head[k] = r_mem[r_rd_ptr];
  end

  assign out_data0 = w_head[0];
  assign out_data1 = w_head[1];
  assign out_data2 = w_head[2];
  assign out_data3 = w_head[3];

`ifdef DEMUX41_COUNT_EN
  logic [15:0] w_xfer [4];

  for (genvar k = 0; k < 4; k++) begin : g_cnt
    logic [15:0] r_xfer;

    // Delivered-word counter; clear takes priority over a same-cycle pop.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_xfer <= 16'd0;
      end else if (cnt_clear) begin
        r_xfer <= 16'd0;
      end else if (w_pop[k]) begin
        r_xfer <= r_xfer + 16'd1;
      end
    end

    assign w_xfer[k] = r_xfer;
  end

  assign xfer_cnt0 = w_xfer[0];
  assign xfer_cnt1 = w_xfer[1];
  assign xfer_cnt2 = w_xfer[2];
  assign xfer_cnt3 = w_xfer[3];
`endif

endmodule

// File: tb/tb_demux14_buffered.sv
// Testbench for demux14_buffered: directed scenarios plus randomized traffic,
// compared against a queue-based reference model of four 2-deep FIFOs.
module tb_demux14_buffered;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic [1:0]   in_sel = 2'b00;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready = 4'b0000;
  logic [N-1:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX41_COUNT_EN
  logic         cnt_clear = 1'b0;
  logic [15:0]  xfer_cnt0, xfer_cnt1, xfer_cnt2, xfer_cnt3;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: one queue per channel, plus delivered-word counts.
  logic [N-1:0] mq [4][$];
  int unsigned  mcnt [4];
  logic         last_push = 1'b0;

  demux14_buffered #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3)
`ifdef DEMUX41_COUNT_EN
    ,
    .cnt_clear (cnt_clear),
    .xfer_cnt0 (xfer_cnt0),
    .xfer_cnt1 (xfer_cnt1),
    .xfer_cnt2 (xfer_cnt2),
    .xfer_cnt3 (xfer_cnt3)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] dut_head(input int k);
    case (k)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

`ifdef DEMUX41_COUNT_EN
  function automatic logic [15:0] dut_xfer(input int k);
    case (k)
      0:       return xfer_cnt0;
      1:       return xfer_cnt1;
      2:       return xfer_cnt2;
      default: return xfer_cnt3;
    endcase
  endfunction
`endif

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      mcnt[k] = 0;
    end
  endtask

  // One clock cycle: entered/left at posedge+1 with inputs already driven.
  task automatic cycle();
    logic       exp_rdy;
    logic       push;
    logic [3:0] pops;
    logic [3:0] exp_vld;
    #1;
    exp_rdy = (mq[in_sel].size() != 2);
    chk("in_ready", in_ready, exp_rdy);
    push = in_valid && exp_rdy;
    for (int k = 0; k < 4; k++) pops[k] = (mq[k].size() != 0) && out_ready[k];
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (pops[k]) begin
        void'(mq[k].pop_front());
        mcnt[k] = (mcnt[k] + 1) % 65536;
      end
    end
`ifdef DEMUX41_COUNT_EN
    if (cnt_clear) for (int k = 0; k < 4; k++) mcnt[k] = 0;
`endif
    if (push) mq[in_sel].push_back(in_data);
    last_push = push;
    #1;
    for (int k = 0; k < 4; k++) exp_vld[k] = (mq[k].size() != 0);
    chk("out_valid", out_valid, exp_vld);
    for (int k = 0; k < 4; k++) begin
      if (mq[k].size() != 0) chk($sformatf("head%0d", k), dut_head(k), mq[k][0]);
`ifdef DEMUX41_COUNT_EN
      chk($sformatf("xfer_cnt%0d", k), dut_xfer(k), mcnt[k]);
`endif
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [N-1:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, out_valid, 4'b0000);
    for (int k = 0; k < 4; k++) chk($sformatf("%s_data%0d", tag, k), dut_head(k), '0);
    for (int s = 0; s < 4; s++) begin
      in_sel = s[1:0];
      #1;
      chk($sformatf("%s_in_ready_sel%0d", tag, s), in_ready, 1'b1);
    end
    in_sel = 2'b00;
  endtask

  initial begin
    model_clear();
    #22 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("reset");

    // Single route to ch2, consumer always ready.
    drive(1'b1, 2'b10, 32'hDEADBEEF, 4'b1111);
    cycle();
    chk("single_vld", out_valid, 4'b0100);
    chk("single_data2", out_data2, 32'hDEADBEEF);
    drive(1'b0, 2'b00, '0, 4'b1111);
    cycle();
    chk("single_gone", out_valid, 4'b0000);

    // Back-pressure: fill ch1, other channels still accept.
    drive(1'b1, 2'b01, 32'h1, 4'b0000);
    cycle();
    drive(1'b1, 2'b01, 32'h2, 4'b0000);
    cycle();
    in_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel = s[1:0];
      #1;
      chk($sformatf("bp_in_ready_sel%0d", s), in_ready, (s != 1));
    end
    drive(1'b1, 2'b00, 32'h3, 4'b0000);
    cycle();
    chk("bp_ch0", out_data0, 32'h3);
    drive(1'b0, 2'b00, '0, 4'b0010);
    chk("bp_first", out_data1, 32'h1);
    cycle();
    chk("bp_second", out_data1, 32'h2);
    cycle();
    chk("bp_ch1_empty", out_valid[1], 1'b0);
    drive(1'b0, 2'b00, '0, 4'b1111);
    cycle();

    // Simultaneous push/pop at occupancy 1 on ch3.
    drive(1'b1, 2'b11, 32'hA, 4'b0000);
    cycle();
    drive(1'b1, 2'b11, 32'hB, 4'b1000);
    cycle();
    chk("pp_head", out_data3, 32'hB);
    chk("pp_vld", out_valid, 4'b1000);
    drive(1'b1, 2'b11, 32'hC, 4'b0000);
    cycle();
    chk("pp_cnt2_ready", in_ready, 1'b0);
    drive(1'b0, 2'b00, '0, 4'b1111);
    cycle();
    cycle();

    // Reset mid-operation with ch0 and ch2 full.
    drive(1'b1, 2'b00, 32'h10, 4'b0000); cycle();
    drive(1'b1, 2'b00, 32'h11, 4'b0000); cycle();
    drive(1'b1, 2'b10, 32'h20, 4'b0000); cycle();
    drive(1'b1, 2'b10, 32'h21, 4'b0000); cycle();
    chk("pre_rst_vld", out_valid, 4'b0101);
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", out_valid, 4'b0000);
    chk("async_rst_data0", out_data0, '0);
    chk("async_rst_data2", out_data2, '0);
    model_clear();
    @(posedge clk);
    #2 rst_n = 1'b1;
    check_reset_state("post_rst");
    @(posedge clk);
    #1;
    drive(1'b0, 2'b00, '0, 4'b1111);
    for (int i = 0; i < 4; i++) cycle();

    // Randomized traffic; hold the request while it is not accepted.
    for (int i = 0; i < 400; i++) begin
      if (!(in_valid && !last_push)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = $urandom;
      end
      out_ready = 4'($urandom);
`ifdef DEMUX41_COUNT_EN
      cnt_clear = ($urandom_range(0, 15) == 0);
`endif
      cycle();
    end

`ifdef DEMUX41_COUNT_EN
    drive(1'b0, 2'b00, '0, 4'b1111);
    cnt_clear = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    cnt_clear = 1'b1;
    cycle();
    cnt_clear = 1'b0;
    for (int k = 0; k < 4; k++) chk($sformatf("clr_xfer%0d", k), dut_xfer(k), 16'd0);

    // Five pops from ch1.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b01, $urandom, 4'b0010);
      cycle();
    end
    drive(1'b0, 2'b00, '0, 4'b0010);
    cycle();
    chk("five_xfer1", xfer_cnt1, 16'd5);
    chk("five_xfer0", xfer_cnt0, 16'd0);
    chk("five_xfer2", xfer_cnt2, 16'd0);
    chk("five_xfer3", xfer_cnt3, 16'd0);

    // Clear wins over a same-cycle pop.
    drive(1'b1, 2'b01, 32'h55, 4'b0010);
    cycle();
    drive(1'b0, 2'b00, '0, 4'b0010);
    cnt_clear = 1'b1;
    cycle();
    cnt_clear = 1'b0;
    chk("clr_pop_xfer1", xfer_cnt1, 16'd0);

    // 65536 pops wrap the counter back to 0.
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, 2'b01, $urandom, 4'b0010);
      cycle();
    end
    drive(1'b0, 2'b00, '0, 4'b0010);
    cycle();
    chk("wrap_xfer1", xfer_cnt1, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
